// File: rtl/regfile_bypass_sb_if.sv
// Decode-stage register file bus: read ports, writeback port, issue scoreboard port, debug tap.
// master = pipeline side driving indices/data, slave = the register file.
interface regfile_bypass_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                pend_set;
    logic [AW-1:0]       pend_addr;
    logic                pend_any;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_addr, we, wr_addr, wr_data, pend_set, pend_addr,
        input  rd_data, rd_busy, pend_any, dbg_data
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, pend_set, pend_addr,
        output rd_data, rd_busy, pend_any, dbg_data
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Register file with NRD combinational read ports, optional write-to-read bypass,
// per-register pending scoreboard and a registered debug tap; r0 reads as zero.
module regfile_bypass_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = $clog2(NREGS),
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int DBG_REG = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_bypass_sb_if.slave   bus
);
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_bypass_sb: NRD must be 1..4");
    end
    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_bypass_sb: NREGS must be a power of two >= 2");
    end
    if (DBG_REG < 0 || DBG_REG >= NREGS) begin : g_bad_dbg
        $error("regfile_bypass_sb: DBG_REG out of range");
    end

    localparam logic [AW-1:0] DBG_IDX = AW'(DBG_REG);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [XLEN-1:0]  dbg_q;
    logic [XLEN-1:0]  dbg_nxt;
    logic             wr_hit;
    logic             set_hit;

    // Not qualified by reset: reads during a reset cycle still see the bypass.
    assign wr_hit  = bus.we && (bus.wr_addr != '0);
    assign set_hit = bus.pend_set && (bus.pend_addr != '0);

    always_comb begin
        pend_nxt = pend;
        if (wr_hit) begin
            pend_nxt[bus.wr_addr] = 1'b0;
        end
        // Applied after the clear so a newly issued producer wins on the same index.
        if (set_hit) begin
            pend_nxt[bus.pend_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_comb begin
        dbg_nxt = '0;
        if (DBG_REG != 0) begin
            if (wr_hit && bus.wr_addr == DBG_IDX) begin
                dbg_nxt = bus.wr_data;
            end else begin
                dbg_nxt = regs[DBG_IDX];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend  <= '0;
            dbg_q <= '0;
        end else begin
            if (wr_hit) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
            pend  <= pend_nxt;
            dbg_q <= dbg_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          byp;

        assign addr = bus.rd_addr[p*AW +: AW];
        assign byp  = (BYPASS != 0) && wr_hit && (addr == bus.wr_addr);

        assign bus.rd_data[p*XLEN +: XLEN] = (addr == '0) ? '0 :
                                             byp          ? bus.wr_data :
                                                            regs[addr];
        assign bus.rd_busy[p] = pend[addr] && !byp;
    end

    assign bus.pend_any = |pend;
    assign bus.dbg_data = dbg_q;
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench: a 4-port bypassing instance and a 2-port non-bypassing instance share clock and reset.
module tb_regfile_bypass_sb;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    regfile_bypass_sb_if #(.XLEN(32), .AW(5), .NRD(4)) ifa ();
    regfile_bypass_sb_if #(.XLEN(32), .AW(5), .NRD(2)) ifb ();

    regfile_bypass_sb #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(1), .DBG_REG(5)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    regfile_bypass_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .DBG_REG(5)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifa.we = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.pend_set = 1'b0; ifa.pend_addr = '0;
        ifb.we = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.pend_set = 1'b0; ifb.pend_addr = '0;
    endtask

    task automatic wr_both(input logic [4:0] a, input logic [31:0] d);
        ifa.we = 1'b1; ifa.wr_addr = a; ifa.wr_data = d;
        ifb.we = 1'b1; ifb.wr_addr = a; ifb.wr_data = d;
    endtask

    task automatic set_both(input logic [4:0] a);
        ifa.pend_set = 1'b1; ifa.pend_addr = a;
        ifb.pend_set = 1'b1; ifb.pend_addr = a;
    endtask

    // Port 0 first; ifa takes four indices, ifb the first two.
    task automatic rd_both(input logic [4:0] a0, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] a3);
        ifa.rd_addr = {a3, a2, a1, a0};
        ifb.rd_addr = {a1, a0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle();
        rd_both(5'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        reset = 1'b0;

        // Post-reset state
        rd_both(5'd7, 5'd9, 5'd5, 5'd3);
        mid();
        chk("rst_rd0_a",   ifa.rd_data[31:0], 64'h0);
        chk("rst_busy_a",  ifa.rd_busy,       64'h0);
        chk("rst_pany_a",  ifa.pend_any,      64'h0);
        chk("rst_dbg_a",   ifa.dbg_data,      64'h0);
        chk("rst_rd0_b",   ifb.rd_data[31:0], 64'h0);

        // Reset clears a written register and discards same-cycle write/set
        step();
        wr_both(5'd7, 32'hDEADBEEF);
        step();
        idle();
        mid();
        chk("r7_stored_a", ifa.rd_data[31:0], 64'hDEADBEEF);
        chk("r7_stored_b", ifb.rd_data[31:0], 64'hDEADBEEF);
        step();
        reset = 1'b1;
        wr_both(5'd9, 32'h55);
        set_both(5'd7);
        mid();
        chk("rd_in_rst_a", ifa.rd_data[31:0], 64'hDEADBEEF);
        step();
        reset = 1'b0;
        idle();
        mid();
        chk("rst_r7_a",    ifa.rd_data[31:0], 64'h0);
        chk("rst_r9_a",    ifa.rd_data[63:32], 64'h0);
        chk("rst_pany2_a", ifa.pend_any,      64'h0);
        chk("rst_dbg2_a",  ifa.dbg_data,      64'h0);
        chk("rst_r7_b",    ifb.rd_data[31:0], 64'h0);

        // r0 immutable
        step();
        wr_both(5'd0, 32'h12345678);
        rd_both(5'd0, 5'd0, 5'd0, 5'd0);
        mid();
        chk("r0_byp_a",  ifa.rd_data[31:0], 64'h0);
        step();
        idle();
        mid();
        chk("r0_next_a", ifa.rd_data[31:0], 64'h0);
        step();
        set_both(5'd0);
        step();
        idle();
        mid();
        chk("r0_pany_a", ifa.pend_any, 64'h0);
        chk("r0_busy_a", ifa.rd_busy[0], 64'h0);

        // Bypass vs stored read
        step();
        wr_both(5'd3, 32'h11);
        step();
        wr_both(5'd3, 32'h22);
        rd_both(5'd3, 5'd3, 5'd0, 5'd0);
        mid();
        chk("byp_p0_a",  ifa.rd_data[31:0],  64'h22);
        chk("byp_p1_a",  ifa.rd_data[63:32], 64'h22);
        chk("nbyp_p0_b", ifb.rd_data[31:0],  64'h11);
        chk("nbyp_p1_b", ifb.rd_data[63:32], 64'h11);
        step();
        idle();
        mid();
        chk("nbyp_nxt_b", ifb.rd_data[31:0], 64'h22);
        chk("byp_nxt_a",  ifa.rd_data[31:0], 64'h22);

        // Scoreboard: set r9 in cycle 0, write r9 in cycle 3
        step();
        set_both(5'd9);
        rd_both(5'd9, 5'd0, 5'd0, 5'd0);
        mid();
        chk("sb_c0_busy_a", ifa.rd_busy[0], 64'h0);
        step();
        idle();
        for (int c = 1; c <= 2; c++) begin
            mid();
            chk($sformatf("sb_c%0d_busy_a", c), ifa.rd_busy[0], 64'h1);
            chk($sformatf("sb_c%0d_busy_b", c), ifb.rd_busy[0], 64'h1);
            chk($sformatf("sb_c%0d_pany_a", c), ifa.pend_any,   64'h1);
            step();
        end
        wr_both(5'd9, 32'h99);
        mid();
        chk("sb_c3_busy_a", ifa.rd_busy[0],    64'h0);
        chk("sb_c3_busy_b", ifb.rd_busy[0],    64'h1);
        chk("sb_c3_rd_a",   ifa.rd_data[31:0], 64'h99);
        chk("sb_c3_rd_b",   ifb.rd_data[31:0], 64'h0);
        step();
        idle();
        mid();
        chk("sb_c4_busy_a", ifa.rd_busy[0],    64'h0);
        chk("sb_c4_busy_b", ifb.rd_busy[0],    64'h0);
        chk("sb_c4_pany_a", ifa.pend_any,      64'h0);
        chk("sb_c4_pany_b", ifb.pend_any,      64'h0);
        chk("sb_c4_rd_b",   ifb.rd_data[31:0], 64'h99);

        // Same-index set+clear: set wins; different-index set+clear: both apply
        step();
        set_both(5'd6);
        step();
        set_both(5'd4);
        wr_both(5'd4, 32'hA5);
        step();
        set_both(5'd10);
        wr_both(5'd6, 32'h66);
        step();
        idle();
        rd_both(5'd4, 5'd6, 5'd10, 5'd0);
        mid();
        chk("sim_r4_busy_a", ifa.rd_busy[0],     64'h1);
        chk("sim_r4_data_a", ifa.rd_data[31:0],  64'hA5);
        chk("sim_r6_busy_a", ifa.rd_busy[1],     64'h0);
        chk("sim_r6_data_a", ifa.rd_data[63:32], 64'h66);
        chk("sim_r10_busy_a", ifa.rd_busy[2],    64'h1);
        chk("sim_r4_busy_b", ifb.rd_busy[0],     64'h1);
        chk("sim_r6_busy_b", ifb.rd_busy[1],     64'h0);

        // Re-set of a pending register, then clear; writing a non-pending register
        step();
        set_both(5'd4);
        step();
        idle();
        mid();
        chk("reset_r4_busy_a", ifa.rd_busy[0], 64'h1);
        step();
        wr_both(5'd4, 32'hB6);
        step();
        wr_both(5'd11, 32'h77);
        rd_both(5'd4, 5'd11, 5'd0, 5'd0);
        step();
        wr_both(5'd10, 32'h1010);
        step();
        idle();
        mid();
        chk("clr_r4_busy_a",  ifa.rd_busy[0],     64'h0);
        chk("wr_r11_busy_a",  ifa.rd_busy[1],     64'h0);
        chk("wr_r11_data_a",  ifa.rd_data[63:32], 64'h77);
        chk("clr_all_pany_a", ifa.pend_any,       64'h0);

        // Debug tap with all four ports active
        step();
        wr_both(5'd5, 32'hCAFE0001);
        rd_both(5'd5, 5'd1, 5'd2, 5'd5);
        mid();
        chk("dbg_p0_a",  ifa.rd_data[31:0],   64'hCAFE0001);
        chk("dbg_p1_a",  ifa.rd_data[63:32],  64'h0);
        chk("dbg_p2_a",  ifa.rd_data[95:64],  64'h0);
        chk("dbg_p3_a",  ifa.rd_data[127:96], 64'hCAFE0001);
        chk("dbg_c0_a",  ifa.dbg_data,        64'h0);
        step();
        wr_both(5'd12, 32'hFFFF0000);
        mid();
        chk("dbg_c1_a",  ifa.dbg_data, 64'hCAFE0001);
        chk("dbg_c1_b",  ifb.dbg_data, 64'hCAFE0001);
        step();
        idle();
        mid();
        chk("dbg_c2_a",  ifa.dbg_data, 64'hCAFE0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised integer register file: next generation of the single-write, two-read datapath register file.
- Adds a configurable read-port count, a write-to-read bypass and a synchronous clear.
- Adds a per-register pending scoreboard for pipeline hazard detection, plus a registered debug tap that drives an FPGA-visible register.
- Sits in the decode stage of the pipelined core; writeback drives the write port and issue drives the scoreboard set port.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers (power of two, >= 2)
- AW, $clog2(NREGS), register index width
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value
- DBG_REG, 5, index mirrored onto dbg_data

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read indices, port p at bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port p at bits [p*XLEN +: XLEN]
- rd_busy  out  NRD  port p addresses a pending register
- we  in  1  write enable
- wr_addr  in  AW  write index
- wr_data  in  XLEN  write data
- pend_set  in  1  issue marks pend_addr pending
- pend_addr  in  AW  register the issued instruction will write
- pend_any  out  1  OR of all pending bits
- dbg_data  out  XLEN  registered copy of register DBG_REG

Behaviour:
- Storage: NREGS x XLEN flops. Register 0 is hardwired zero:
  - writes to index 0 are ignored;
  - reads of index 0 return 0 regardless of bypass.
- Reset (reset=1 at a rising edge):
  - all registers, pending bits and dbg_data become 0;
  - we and pend_set are ignored that cycle;
  - consequently all rd_data, rd_busy, pend_any and dbg_data read 0 after the edge.
- Reset asserted mid-operation discards any write or pending set presented in the same cycle.
- Write:
  - on a rising edge with we=1, reset=0, wr_addr!=0: reg[wr_addr] <= wr_data;
  - visible in stored state from the next cycle.
- Read (combinational, zero latency):
  - rd_data[p] = reg[rd_addr[p]];
  - if BYPASS=1, we=1 and rd_addr[p]==wr_addr!=0, rd_data[p] = wr_data in the same cycle;
  - all ports are independent; any number of ports may read the same index;
  - during a cycle with reset=1, reads still reflect pre-edge stored state (plus bypass).
- Scoreboard (one pending bit per register; bit 0 is constant 0):
  - set: pend_set=1 and pend_addr!=0 sets pend[pend_addr] at the edge;
  - clear: we=1 and wr_addr!=0 clears pend[wr_addr] at the edge;
  - set and clear on the same index in the same cycle: set wins (a new producer was issued);
  - set and clear on different indices in the same cycle: both take effect;
  - re-setting an already pending register is legal and leaves it pending (no counting);
  - writing a non-pending register is legal; pend stays 0.
- rd_busy[p] = pend[rd_addr[p]], combinational, and reflects registered state only:
  - with BYPASS=1, a same-cycle clear of that register forces rd_busy[p]=0 (data is being bypassed);
  - with BYPASS=0, a same-cycle clear does not force rd_busy[p]=0.
- pend_any is the combinational OR of registered pend bits.
- Debug tap:
  - dbg_data <= (next value of reg[DBG_REG]) each edge, i.e. it equals reg[DBG_REG] one cycle after the write edge that updates it;
  - if DBG_REG=0 it is constant 0.
- Illegal parameters (NRD outside 1..4, DBG_REG >= NREGS, NREGS not a power of two) stop elaboration via an elaboration-time assertion.
- No X propagation: every register has a defined value after the first reset.

Test Plan:
- Reset clears state:
  - stimulus: write 0xDEADBEEF to r7, then assert reset 1 cycle;
  - required: rd_addr0=7 gives rd_data0=0, dbg_data=0, pend_any=0.
- r0 is immutable:
  - stimulus: we=1, wr_addr=0, wr_data=0x12345678; same cycle rd_addr0=0 with BYPASS=1; then pend_set with pend_addr=0;
  - required: rd_data0=0 in that cycle and the next; pend_any stays 0.
- Bypass:
  - stimulus: BYPASS=1, r3=0x11, then same cycle we=1, wr_addr=3, wr_data=0x22, rd_addr0=3, rd_addr1=3;
  - required: both ports read 0x22 that cycle;
  - repeat with BYPASS=0: required 0x11 that cycle, 0x22 the next.
- Scoreboard set/clear:
  - stimulus: pend_set r9 at cycle 0; write r9 at cycle 3;
  - required: rd_busy0=1 (rd_addr0=9) in cycles 1-3; with BYPASS=1 rd_busy0=0 in cycle 3; rd_busy0=0 and pend_any=0 from cycle 4.
- Simultaneous events:
  - stimulus: same cycle pend_set r4, we r4 = 0xA5, and write r6 while r6 is pending;
  - required: next cycle r4 pending with value 0xA5, r6 not pending.
- Debug tap and wide config:
  - stimulus: NRD=4, DBG_REG=5; write 0xCAFE0001 to r5 at cycle 0 while all 4 ports read r5, r1, r2, r5;
  - required: ports 0 and 3 bypass 0xCAFE0001 in cycle 0; dbg_data=0xCAFE0001 from cycle 1.
